// File: rtl/dm_obi_slave_arbiter.sv
// Round-robin arbiter sharing the debug module OBI slave port among several OBI
// managers, with address-phase locking, an outstanding cap and in-order response routing.
module dm_obi_slave_arbiter #(
  parameter int unsigned NrPorts        = 2,
  parameter int unsigned BusWidth       = 32,
  parameter int unsigned IdWidth        = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NrPorts-1:0]                    req_i,
  output logic [NrPorts-1:0]                    gnt_o,
  input  logic [NrPorts-1:0]                    we_i,
  input  logic [NrPorts-1:0][BusWidth/8-1:0]    be_i,
  input  logic [NrPorts-1:0][BusWidth-1:0]      addr_i,
  input  logic [NrPorts-1:0][BusWidth-1:0]      wdata_i,
  input  logic [NrPorts-1:0][IdWidth-1:0]       aid_i,
  output logic [NrPorts-1:0]                    rvalid_o,
  output logic [BusWidth-1:0]                   rdata_o,
  output logic [IdWidth-1:0]                    rid_o,
  output logic                                  dm_req_o,
  input  logic                                  dm_gnt_i,
  output logic                                  dm_we_o,
  output logic [BusWidth/8-1:0]                 dm_be_o,
  output logic [BusWidth-1:0]                   dm_addr_o,
  output logic [BusWidth-1:0]                   dm_wdata_o,
  output logic [IdWidth-1:0]                    dm_aid_o,
  input  logic                                  dm_rvalid_i,
  input  logic [BusWidth-1:0]                   dm_rdata_i,
  input  logic [IdWidth-1:0]                    dm_rid_i,
  output logic                                  protocol_err_o
);

  localparam int unsigned IdxW = (NrPorts > 1) ? $clog2(NrPorts) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  idx_t rr_ptr_r;
  logic lock_r;
  idx_t lock_idx_r;
  idx_t fifo_mem_r [MaxOutstanding];
  ptr_t wptr_r;
  ptr_t rptr_r;
  cnt_t count_r;
  logic err_r;

  idx_t sel_s;
  idx_t scan_s;
  logic found_s;
  logic issue_allowed_s;
  logic handshake_s;
  logic pop_s;
  idx_t head_s;

  function automatic idx_t wrap_inc_idx(input idx_t v);
    if (v == idx_t'(NrPorts - 1)) begin
      return {IdxW{1'b0}};
    end else begin
      return v + idx_t'(1);
    end
  endfunction

  function automatic ptr_t wrap_inc_ptr(input ptr_t v);
    if (v == ptr_t'(MaxOutstanding - 1)) begin
      return {PtrW{1'b0}};
    end else begin
      return v + ptr_t'(1);
    end
  endfunction

  // Port selection: locked port wins, otherwise first requester at/after the pointer
  always_comb begin
    sel_s   = rr_ptr_r;
    scan_s  = rr_ptr_r;
    found_s = 1'b0;
    if (lock_r) begin
      sel_s = lock_idx_r;
    end else begin
      for (int unsigned i = 0; i < NrPorts; i++) begin
        sel_s   = (!found_s && req_i[scan_s]) ? scan_s : sel_s;
        found_s = found_s | req_i[scan_s];
        scan_s  = wrap_inc_idx(scan_s);
      end
    end
  end

  // Issue is capped by the outstanding count only; a same-cycle response does not free a slot
  assign issue_allowed_s = (count_r < cnt_t'(MaxOutstanding));
  assign dm_req_o        = rst_ni & issue_allowed_s & req_i[sel_s];
  assign handshake_s     = dm_req_o & dm_gnt_i;
  assign pop_s           = rst_ni & dm_rvalid_i & (count_r != {CntW{1'b0}});
  assign head_s          = fifo_mem_r[rptr_r];

  assign dm_we_o    = we_i[sel_s];
  assign dm_be_o    = be_i[sel_s];
  assign dm_addr_o  = addr_i[sel_s];
  assign dm_wdata_o = wdata_i[sel_s];
  assign dm_aid_o   = aid_i[sel_s];

  assign rdata_o        = dm_rdata_i;
  assign rid_o          = dm_rid_i;
  assign protocol_err_o = err_r;

  // Grant reflects the DM handshake onto the selected port only
  always_comb begin
    gnt_o        = {NrPorts{1'b0}};
    gnt_o[sel_s] = handshake_s;
  end

  // Response valid is steered to the port at the head of the index FIFO
  always_comb begin
    rvalid_o         = {NrPorts{1'b0}};
    rvalid_o[head_s] = pop_s;
  end

  // Round-robin pointer and address-phase lock
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_r   <= {IdxW{1'b0}};
      lock_r     <= 1'b0;
      lock_idx_r <= {IdxW{1'b0}};
    end else begin
      lock_r     <= dm_req_o & ~dm_gnt_i;
      lock_idx_r <= sel_s;
      if (handshake_s) begin
        rr_ptr_r <= wrap_inc_idx(sel_s);
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  // Index FIFO storage and pointers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_r <= {PtrW{1'b0}};
      rptr_r <= {PtrW{1'b0}};
      for (int unsigned k = 0; k < MaxOutstanding; k++) begin
        fifo_mem_r[k] <= {IdxW{1'b0}};
      end
    end else begin
      if (handshake_s) begin
        fifo_mem_r[wptr_r] <= sel_s;
        wptr_r             <= wrap_inc_ptr(wptr_r);
      end else begin
        wptr_r <= wptr_r;
      end
      if (pop_s) begin
        rptr_r <= wrap_inc_ptr(rptr_r);
      end else begin
        rptr_r <= rptr_r;
      end
    end
  end

  // Outstanding transaction count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_r <= {CntW{1'b0}};
    end else begin
      case ({handshake_s, pop_s})
        2'b10:   count_r <= count_r + cnt_t'(1);
        2'b01:   count_r <= count_r - cnt_t'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky flag for a response arriving with nothing outstanding
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | (dm_rvalid_i & (count_r == {CntW{1'b0}}));
    end
  end

endmodule
